// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit holding the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per CALC cycle.
module muldiv_hilo #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             wrHi,
  input  logic             wrLo,
  input  logic [width-1:0] wrData,
  output logic [width-1:0] hi,
  output logic [width-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(width) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t             state, next_state;
  logic [CW-1:0]      cnt;
  logic [width-1:0]   a_r;
  logic [width-1:0]   opnd;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               b_zero;
  logic [2*width-1:0] acc;

  logic               sgn;
  logic [width-1:0]   mag_a, mag_b;
  logic [width:0]     msum;
  logic [width:0]     shifted;
  logic               ge;
  logic [width-1:0]   sub;
  logic [2*width-1:0] acc_step;
  logic [2*width-1:0] prod_f;
  logic [width-1:0]   quot_f, rem_f;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (cnt == CW'(width - 1)) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sgn   = ~op[0];
    mag_a = (sgn && A[width-1]) ? -A : A;
    mag_b = (sgn && B[width-1]) ? -B : B;
  end

  // acc is {product high, multiplier} for mult, {remainder, quotient} for div
  always_comb begin
    msum     = '0;
    shifted  = '0;
    ge       = 1'b0;
    sub      = '0;
    acc_step = acc;
    if (is_div) begin
      shifted = {acc[2*width-1:width], acc[width-1]};
      ge      = (shifted >= {1'b0, opnd});
      sub     = shifted[width-1:0] - opnd;
      if (ge) acc_step = {sub, acc[width-2:0], 1'b1};
      else    acc_step = {shifted[width-1:0], acc[width-2:0], 1'b0};
    end else begin
      msum     = {1'b0, acc[2*width-1:width]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_step = {msum, acc[width-1:1]};
    end
  end

  always_comb begin
    prod_f = neg_res ? -acc : acc;
    quot_f = neg_res ? -acc[width-1:0] : acc[width-1:0];
    rem_f  = neg_rem ? -acc[2*width-1:width] : acc[2*width-1:width];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      a_r     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      acc     <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            a_r     <= A;
            is_div  <= op[1];
            neg_res <= sgn & (A[width-1] ^ B[width-1]);
            neg_rem <= sgn & op[1] & A[width-1];
            b_zero  <= (B == '0);
            opnd    <= op[1] ? mag_b : mag_a;
            acc     <= op[1] ? {{width{1'b0}}, mag_a} : {{width{1'b0}}, mag_b};
          end else begin
            if (wrHi) hi <= wrData;
            if (wrLo) lo <= wrData;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        FINISH: begin
          if (!is_div) begin
            {hi, lo} <= prod_f;
          end else if (b_zero) begin
            hi <= a_r;
            lo <= '1;
          end else begin
            hi <= rem_f;
            lo <= quot_f;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: directed vectors plus a reference-model sweep.
module tb_muldiv_hilo;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, start, wrHi, wrLo;
  logic [1:0]    op;
  logic [W-1:0]  A, B, wrData, hi, lo;
  logic          busy, done;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  muldiv_hilo #(.width(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .wrHi(wrHi), .wrLo(wrLo), .wrData(wrData),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    string       n;
    logic [63:0] e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no pending result", hi, lo);
      end else begin
        n = name_q.pop_front();
        e = exp_q.pop_front();
        check(n, {hi, lo}, e);
      end
    end
  end

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: q = sa * sb;
      2'b01: q = ua * ub;
      2'b10: begin
        sq = sa / sb;
        sr = sa % sb;
        q  = sq;
        r  = sr;
        q  = {r[31:0], q[31:0]};
      end
      default: begin
        q = ua / ub;
        r = ua % ub;
        q = {r[31:0], q[31:0]};
      end
    endcase
    return q;
  endfunction

  // Called at a negedge with the DUT idle (or showing done); returns at the next negedge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string nm);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    start = 1'b0;
    check({"busy_", nm}, 64'(busy), 64'd1);
  endtask

  // k0 = negedges already elapsed since the start was driven
  task automatic wait_done(input string nm, input int k0);
    int k;
    k = k0;
    while (done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({"latency_", nm}, 64'(k), 64'd34);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input string nm);
    issue(o, a, b, exp, nm);
    wait_done(nm, 1);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; wrHi = 1'b0; wrLo = 1'b0;
    op = 2'b00; A = '0; B = '0; wrData = '0;
    repeat (2) @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_flags", 64'({busy, done}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    wrHi = 1'b1; wrLo = 1'b1; wrData = 32'hCAFE;
    @(negedge clk);
    wrHi = 1'b0; wrLo = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'hCAFE, 32'hCAFE});
    check("mt_no_busy", 64'({busy, done}), 64'd0);
    wrHi = 1'b1; wrData = 32'h1234;
    @(negedge clk);
    wrHi = 1'b0;
    check("mthi_only", {hi, lo}, {32'h1234, 32'hCAFE});

    // Abort a mult 7x9 mid-calculation with an asynchronous reset
    start = 1'b1; op = 2'b00; A = 32'd7; B = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_flags", 64'({busy, done}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_idle", 64'({busy, done}), 64'd0);

    run(2'b00, 32'hFFFFFFFE, 32'd3, {32'hFFFFFFFF, 32'hFFFFFFFA}, "mult_neg2x3");
    run(2'b01, 32'hFFFFFFFE, 32'd3, {32'h00000002, 32'hFFFFFFFA}, "multu_big");
    run(2'b10, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, "div_neg7_2");
    run(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, "divu_100_7");
    run(2'b10, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, "div_overflow");
    run(2'b10, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'hFFFFFFFF}, "div_by_zero");
    run(2'b11, 32'h1234, 32'd0, {32'h1234, 32'hFFFFFFFF}, "divu_by_zero");

    // Disturb inputs while busy; hi/lo must hold the divu-by-zero result
    issue(2'b01, 32'd5, 32'd6, {32'd0, 32'd30}, "busy_disturb");
    A = '1; B = '1; op = 2'b10; start = 1'b1; wrHi = 1'b1; wrData = 32'hDEAD;
    @(negedge clk);
    check("busy_hold1", {hi, lo}, {32'h1234, 32'hFFFFFFFF});
    start = 1'b0; A = 32'h55; B = 32'h0;
    @(negedge clk);
    wrHi = 1'b0; wrLo = 1'b1;
    @(negedge clk);
    wrLo = 1'b0;
    check("busy_hold2", {hi, lo}, {32'h1234, 32'hFFFFFFFF});
    wait_done("busy_disturb", 4);

    // start and wrLo together: the write is dropped
    wrLo = 1'b1; wrData = 32'h1111;
    issue(2'b01, 32'd2, 32'd3, {32'd0, 32'd6}, "start_wins");
    wrLo = 1'b0;
    check("start_wins_lo", 64'(lo), 64'd30);
    wait_done("start_wins", 1);

    for (int i = 0; i < 1000; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 4 == 1) ra = ra >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd1;
      run(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d_op%0d", i, ro));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Iterative multiply/divide unit owning the architectural HI/LO registers of the single-cycle MIPS datapath. It takes the same register operands as the ALU and executes mult/multu/div/divu over width+1 cycles. It holds HI/LO and feeds them back to the ALU `hi`/`lo` inputs for mfhi/mflo. It also accepts direct mthi/mtlo writes. The control unit stalls the PC while `busy` is high.

## Interface
- `width`, default 32: operand and HI/LO width (even, ≥ 4).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request an operation; sampled only when `busy`=0.
- `op`  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- `A`  in  width  rs operand (multiplicand / dividend).
- `B`  in  width  rt operand (multiplier / divisor).
- `wrHi`, `wrLo`  in  1 each  mthi / mtlo write enables.
- `wrData`  in  width  data for mthi/mtlo.
- `hi`, `lo`  out  width  registered HI/LO values.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO receive a result.

## Operation
- FSM states: IDLE, CALC, FINISH.
  - IDLE → CALC on `start`.
  - CALC → FINISH after exactly `width` iterations, tracked by a ⌈log2(width)⌉+1-bit counter.
  - FINISH → IDLE unconditionally.
- On accept, the block latches `op`, `A` and `B` internally. Operand inputs may change afterwards without effect.
- Signed ops (mult, div) first convert operands to magnitudes and record the result signs.
- Multiply: radix-2 shift-add, one bit per CALC cycle, into a 2·width accumulator.
  - FINISH negates the product if the signs differ, then writes {hi,lo} = product.
  - Result must equal `$signed(A)*$signed(B)` for mult and unsigned A*B for multu, full 2·width bits.
- Divide: radix-2 restoring, one quotient bit per CALC cycle.
  - FINISH applies signs: quotient negated if the operand signs differ; remainder takes the dividend's sign (truncate toward zero).
  - Then lo = quotient, hi = remainder.
- Divide boundary cases:
  - B=0 (div or divu): lo = all ones, hi = A unchanged. Normal latency, no exception.
  - div with A = most-negative and B = −1: lo = A (0x80000000 at width 32), hi = 0.
- mthi/mtlo: in IDLE with `start`=0, `wrHi`/`wrLo` load `wrData` into hi/lo at the next edge. Both may be asserted together.
- Write priority and ignores:
  - `start` in the same IDLE cycle as `wrHi`/`wrLo`: start wins and the write is dropped.
  - `wrHi`/`wrLo` while `busy`=1: ignored.
  - `start` while `busy`=1: ignored.
- hi/lo never change during CALC. The ALU sees the old values until `done`.

## Timing
- Reset (async, immediate): state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, internal operand registers cleared.
- Reset mid-operation aborts: no result is written, and hi/lo return to 0.
- Let E0 be the edge that samples `start`=1 in IDLE.
  - `busy` goes high after E0.
  - CALC occupies edges E1..E(width); FINISH executes at edge E(width+1).
  - At E(width+1): hi/lo are updated, `done`=1 for exactly one cycle, and `busy` drops.
- Stall length is width+1 cycles. A new `start` can be accepted in the same cycle `done` is high.
- mthi/mtlo latency: 1 edge. `done` is not asserted for writes.
- `busy`, `done`, `hi`, `lo` are all registered outputs with no combinational input path.

## Test plan
- Reset during CALC of mult 7×9 → hi=0, lo=0, busy=0 immediately; no `done` pulse.
- mult A=0xFFFFFFFE (−2), B=3 → after 33 cycles {hi,lo}=0xFFFFFFFF_FFFFFFFA, done pulse 1 cycle; multu same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div A=−7 (0xFFFFFFF9), B=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); divu A=100, B=7 → lo=14, hi=2.
- div A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0. divu A=0x1234, B=0 → lo=0xFFFFFFFF, hi=0x1234.
- While busy: toggle A/B, pulse start, and assert wrHi with 0xDEAD → result unaffected, hi/lo unchanged until done, write ignored.
- Idle: wrHi+wrLo with 0xCAFE → both 0xCAFE next edge. Then start and wrLo in the same cycle → operation runs and the write is dropped.
- Randomized: 1000 ops checked against the `$signed`/unsigned `*`, `/`, `%` reference model (B≠0).
